// File: rtl/sram_pkg.sv
// Shared definitions for the data-SRAM responder.
// Contents: wait-state FSM encoding, the largest supported WAIT_CYCLES,
// the counter width that covers it, and the request-register field widths.
package sram_pkg;

    // Largest supported number of extra stall cycles per access.
    localparam int unsigned WaitCyclesMax = 15;
    localparam int unsigned CntWidth      = 4;

    // Request-register field widths (match the CPU data-SRAM bus).
    localparam int unsigned BusAddrWidth  = 32;
    localparam int unsigned WenWidth      = 4;
    localparam int unsigned DataWidth     = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } sram_state_e;

    // Latched write strobes and data. The word index is held separately
    // because its width depends on the array size.
    typedef struct packed {
        logic [WenWidth-1:0]  wen;
        logic [DataWidth-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_bytewe_array.sv
// Word-organised storage with per-byte write strobes and one synchronous
// read port. Written to map onto block RAM with a resettable output register.
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-low reset (output register only)
//   en     in   access strobe for this cycle
//   wen    in   byte-lane write enables; all-zero means read
//   idx    in   word index
//   wdata  in   write data, lane-aligned
//   rdata  out  registered read data; holds unless a read completes
module sram_bytewe_array
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [WenWidth-1:0]   wen,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [DataWidth-1:0]  wdata,
    output logic [DataWidth-1:0]  rdata
);

    // Contents are deliberately not reset.
    logic [DataWidth-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < int'(WenWidth); i++) begin
                if (wen[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // No read-during-write: a write leaves the output register untouched.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= '0;
        end else if (en && (wen == '0)) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/data_sram_resp.sv
// Responder for the core's data-SRAM port. Performs byte-lane writes and
// registered word reads, optionally stretching each access by WAIT_CYCLES
// stall cycles through a small IDLE/WAIT/DONE FSM.
// Ports:
//   clk              in   clock
//   rst              in   synchronous active-low reset
//   data_sram_en     in   access request
//   data_sram_wen    in   byte write enables (0 = read)
//   data_sram_addr   in   byte address; word index is addr[ADDR_WIDTH+1:2]
//   data_sram_wdata  in   write data
//   data_sram_rdata  out  registered read data
//   stallreq         out  stall request to pipeline control
module data_sram_resp
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    data_sram_en,
    input  logic [WenWidth-1:0]     data_sram_wen,
    input  logic [BusAddrWidth-1:0] data_sram_addr,
    input  logic [DataWidth-1:0]    data_sram_wdata,
    output logic [DataWidth-1:0]    data_sram_rdata,
    output logic                    stallreq
);

    // Access presented to the array this cycle.
    logic                  acc_en;
    logic [WenWidth-1:0]   acc_wen;
    logic [ADDR_WIDTH-1:0] acc_idx;
    logic [DataWidth-1:0]  acc_wdata;

    logic [ADDR_WIDTH-1:0] live_idx;
    logic                  unused_addr_bits;

    // Byte offset and bits above the array size alias onto the same word.
    assign live_idx         = data_sram_addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{data_sram_addr[BusAddrWidth-1:ADDR_WIDTH+2],
                                data_sram_addr[1:0]};

    if (WAIT_CYCLES == 0) begin : g_nowait
        assign acc_en    = rst & data_sram_en;
        assign acc_wen   = data_sram_wen;
        assign acc_idx   = live_idx;
        assign acc_wdata = data_sram_wdata;
        assign stallreq  = 1'b0;
    end else begin : g_wait
        // The counter holds the WAIT cycles remaining after the current one,
        // so a load of N-2 yields N stall cycles counting the IDLE cycle.
        localparam int unsigned CntLoad = (WAIT_CYCLES > 1) ? WAIT_CYCLES - 2 : 0;
        localparam logic [CntWidth-1:0] CntInit = CntWidth'(CntLoad);

        sram_state_e           state_q;
        logic [CntWidth-1:0]   cnt_q;
        sram_req_t             req_q;
        logic [ADDR_WIDTH-1:0] req_idx_q;

        always_ff @(posedge clk) begin
            if (!rst) begin
                state_q   <= StIdle;
                cnt_q     <= '0;
                req_q     <= '0;
                req_idx_q <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (data_sram_en) begin
                            req_q.wen   <= data_sram_wen;
                            req_q.wdata <= data_sram_wdata;
                            req_idx_q   <= live_idx;
                            cnt_q       <= CntInit;
                            // With one wait cycle the access completes from IDLE.
                            state_q     <= (WAIT_CYCLES == 1) ? StDone : StWait;
                        end
                    end
                    StWait: begin
                        if (cnt_q == '0) begin
                            state_q <= StDone;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    StDone: begin
                        // en here is the same instruction still on the bus.
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end

        always_comb begin
            acc_en    = 1'b0;
            acc_wen   = '0;
            acc_idx   = '0;
            acc_wdata = '0;
            if ((state_q == StIdle) && (WAIT_CYCLES == 1)) begin
                acc_en    = data_sram_en;
                acc_wen   = data_sram_wen;
                acc_idx   = live_idx;
                acc_wdata = data_sram_wdata;
            end else if ((state_q == StWait) && (cnt_q == '0)) begin
                // Completion always uses the latched request.
                acc_en    = 1'b1;
                acc_wen   = req_q.wen;
                acc_idx   = req_idx_q;
                acc_wdata = req_q.wdata;
            end
            // A reset cycle drops any pending access.
            acc_en = acc_en & rst;
        end

        assign stallreq = rst & ((state_q == StWait) |
                                 ((state_q == StIdle) & data_sram_en));
    end

    sram_bytewe_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .en    (acc_en),
        .wen   (acc_wen),
        .idx   (acc_idx),
        .wdata (acc_wdata),
        .rdata (data_sram_rdata)
    );

endmodule
